// File: rtl/if_fetch_unit.sv
`default_nettype none
// if_fetch_unit: IF stage owning the fetch PC, the bus read handshake and the IF/ID register.
// Optional macro IF_FETCH_TIMEOUT_EN adds an ACCESS timeout that presents a bus-error slot.
module if_fetch_unit #(
  parameter logic [29:0] RESET_PC    = 30'h0,
  parameter int unsigned BUS_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [29:0] new_pc,
  input  logic        br_taken,
  input  logic [29:0] br_addr,
  output logic        bus_req_,
  input  logic        bus_grnt_,
  output logic [29:0] bus_addr,
  output logic        bus_as_,
  output logic        bus_rw,
  input  logic [31:0] bus_rd_data,
  input  logic        bus_rdy_,
  output logic [29:0] if_pc,
  output logic [31:0] if_insn,
  output logic        if_en,
  output logic        busy,
  output logic        if_bus_err
);

  localparam logic        READ = 1'b1;
  localparam logic [31:0] NOP  = 32'h0;

  typedef enum logic [1:0] {IDLE, REQ, ACCESS, HOLD} state_t;
  state_t state, state_next;

  logic [29:0] fetch_pc;
  logic [31:0] buffer;
  logic        discard;
  logic        first;

  logic        redirect;
  logic [29:0] redirect_pc;
  logic [29:0] pc_inc;
  logic        rdy;
  logic        deliver_bus;
  logic        deliver_buf;
  logic        to_hold;
  logic        timeout;
  logic        timeout_present;

  assign redirect    = flush | br_taken;
  assign redirect_pc = flush ? new_pc : br_addr;
  assign pc_inc      = fetch_pc + 30'd1;
  assign rdy         = (state == ACCESS) && !bus_rdy_;
  // A redirect in the completing cycle wins: the word belongs to the old path.
  assign deliver_bus = rdy && !discard && !redirect && !stall;
  assign to_hold     = rdy && !discard && !redirect && stall;
  assign deliver_buf = (state == HOLD) && !redirect && !stall;

`ifdef IF_FETCH_TIMEOUT_EN
  localparam int unsigned CW = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(BUS_TIMEOUT - 1);
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                cnt <= '0;
    else if (state != ACCESS)  cnt <= '0;
    else if (cnt != CNT_MAX)   cnt <= cnt + 1'b1;
  end

  // Under stall the counter saturates and the error slot waits for ID to accept it.
  assign timeout         = (state == ACCESS) && bus_rdy_ && (cnt == CNT_MAX) && (discard || redirect || !stall);
  assign timeout_present = timeout && !discard && !redirect;
`else
  assign timeout         = 1'b0;
  assign timeout_present = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    bus_req_   = 1'b1;
    bus_as_    = 1'b1;
    busy       = 1'b0;
    bus_rw     = READ;
    unique case (state)
      IDLE: if (!stall) state_next = REQ;
      REQ: begin
        bus_req_ = 1'b0;
        busy     = 1'b1;
        if (!bus_grnt_) state_next = ACCESS;
      end
      ACCESS: begin
        bus_req_ = 1'b0;
        busy     = 1'b1;
        bus_as_  = !first;
        if (!bus_rdy_)    state_next = to_hold ? HOLD : REQ;
        else if (timeout) state_next = IDLE;
      end
      HOLD: if (redirect || !stall) state_next = REQ;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc   <= RESET_PC;
      bus_addr   <= 30'h0;
      first      <= 1'b0;
      discard    <= 1'b0;
      buffer     <= NOP;
      if_pc      <= RESET_PC;
      if_insn    <= NOP;
      if_en      <= 1'b0;
      if_bus_err <= 1'b0;
    end else begin
      first <= (state == REQ) && !bus_grnt_;
      if ((state == REQ) && !bus_grnt_) bus_addr <= fetch_pc;

      // discard marks an in-flight access whose data belongs to a dead path.
      if (state_next != ACCESS) discard <= 1'b0;
      else if (redirect)        discard <= 1'b1;

      if (to_hold) buffer <= bus_rd_data;

      if (redirect)                        fetch_pc <= redirect_pc;
      else if (deliver_bus || deliver_buf) fetch_pc <= pc_inc;

      if (flush) begin
        if_en      <= 1'b0;
        if_insn    <= NOP;
        if_bus_err <= 1'b0;
      end else if (br_taken) begin
        if_en <= 1'b0;
      end else if (deliver_bus || deliver_buf) begin
        if_insn    <= deliver_bus ? bus_rd_data : buffer;
        if_pc      <= pc_inc;
        if_en      <= 1'b1;
        if_bus_err <= 1'b0;
      end else if (timeout_present) begin
        if_insn    <= NOP;
        if_pc      <= pc_inc;
        if_en      <= 1'b1;
        if_bus_err <= 1'b1;
      end else if (!stall) begin
        if_en <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// Scoreboard bench for if_fetch_unit: expected bus addresses and IF/ID slots are queued, monitors pop them.
module tb_if_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [29:0] new_pc;
  logic        br_taken;
  logic [29:0] br_addr;
  logic        bus_req_;
  logic        bus_grnt_;
  logic [29:0] bus_addr;
  logic        bus_as_;
  logic        bus_rw;
  logic [31:0] bus_rd_data;
  logic        bus_rdy_;
  logic [29:0] if_pc;
  logic [31:0] if_insn;
  logic        if_en;
  logic        busy;
  logic        if_bus_err;

  if_fetch_unit #(.RESET_PC(30'h0), .BUS_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .new_pc(new_pc),
    .br_taken(br_taken), .br_addr(br_addr), .bus_req_(bus_req_), .bus_grnt_(bus_grnt_),
    .bus_addr(bus_addr), .bus_as_(bus_as_), .bus_rw(bus_rw), .bus_rd_data(bus_rd_data),
    .bus_rdy_(bus_rdy_), .if_pc(if_pc), .if_insn(if_insn), .if_en(if_en), .busy(busy),
    .if_bus_err(if_bus_err)
  );

  typedef struct packed {
    logic [29:0] pc;
    logic [31:0] insn;
    logic        err;
  } slot_t;

  slot_t       exp_slots[$];
  logic [29:0] exp_addrs[$];
  int          checks   = 0;
  int          failures = 0;
  bit          rdy_never = 0;
  logic        stall_at_edge;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word(input logic [29:0] a);
    word = (a == 30'h0) ? 32'h1234_5678 : (32'hA5A5_0000 | {2'b00, a});
  endfunction

  // Bus slave: read data valid one cycle after the address strobe.
  initial begin : bus_model
    bit          pend;
    logic [29:0] addr_l;
    pend        = 0;
    addr_l      = '0;
    bus_rdy_    = 1'b1;
    bus_rd_data = 32'h0;
    forever begin
      @(negedge clk);
      bus_rdy_ = 1'b1;
      if (bus_req_) pend = 0;
      if (pend && !rdy_never) begin
        bus_rdy_    = 1'b0;
        bus_rd_data = word(addr_l);
        pend        = 0;
      end
      if (!bus_as_) begin
        pend   = 1;
        addr_l = bus_addr;
      end
    end
  end

  always @(posedge clk) stall_at_edge <= stall;

  initial begin : monitor
    slot_t       s;
    logic [29:0] a;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (!bus_as_) begin
          if (exp_addrs.size() == 0) begin
            chk("unexpected_as", {34'h0, bus_addr}, 64'hFFFF_FFFF);
          end else begin
            a = exp_addrs.pop_front();
            chk("bus_addr", {34'h0, bus_addr}, {34'h0, a});
          end
        end
        if (if_en && !stall_at_edge) begin
          if (exp_slots.size() == 0) begin
            chk("unexpected_slot", {32'h0, if_insn}, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            s = exp_slots.pop_front();
            chk("if_pc", {34'h0, if_pc}, {34'h0, s.pc});
            chk("if_insn", {32'h0, if_insn}, {32'h0, s.insn});
            chk("if_bus_err", {63'h0, if_bus_err}, {63'h0, s.err});
          end
        end
      end
    end
  end

  task automatic fetch_grant(input logic [29:0] addr);
    bit seen;
    seen = 0;
    exp_addrs.push_back(addr);
    bus_grnt_ = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus_as_) begin
        seen = 1;
        break;
      end
    end
    bus_grnt_ = 1'b1;
    if (!seen) chk("as_timeout", 64'h0, 64'h1);
  endtask

  initial begin : stimulus
    slot_t s;
    reset     = 1'b0;
    stall     = 1'b0;
    flush     = 1'b0;
    new_pc    = '0;
    br_taken  = 1'b0;
    br_addr   = '0;
    bus_grnt_ = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_if_pc", {34'h0, if_pc}, 64'h0);
    chk("rst_if_insn", {32'h0, if_insn}, 64'h0);
    chk("rst_if_en", {63'h0, if_en}, 64'h0);
    chk("rst_bus_req", {63'h0, bus_req_}, 64'h1);
    chk("rst_bus_as", {63'h0, bus_as_}, 64'h1);
    chk("rst_bus_rw", {63'h0, bus_rw}, 64'h1);
    chk("rst_bus_addr", {34'h0, bus_addr}, 64'h0);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_if_bus_err", {63'h0, if_bus_err}, 64'h0);
    reset = 1'b1;

    // grant withheld: request held, no strobe, no instruction
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("nogrant_req", {63'h0, bus_req_}, 64'h0);
      chk("nogrant_as", {63'h0, bus_as_}, 64'h1);
      chk("nogrant_busy", {63'h0, busy}, 64'h1);
      chk("nogrant_if_en", {63'h0, if_en}, 64'h0);
    end

    // first fetch from reset PC
    s = '{pc: 30'h1, insn: 32'h1234_5678, err: 1'b0};
    exp_slots.push_back(s);
    fetch_grant(30'h0);
    @(negedge clk);
    chk("as_single_pulse", {63'h0, bus_as_}, 64'h1);
    repeat (2) @(negedge clk);
    chk("bubble_if_en", {63'h0, if_en}, 64'h0);
    chk("parked_req", {63'h0, bus_req_}, 64'h0);

    // stall when data returns: held in buffer, bus released
    stall = 1'b1;
    s = '{pc: 30'h2, insn: 32'hA5A5_0001, err: 1'b0};
    exp_slots.push_back(s);
    fetch_grant(30'h1);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_if_insn", {32'h0, if_insn}, 64'h1234_5678);
      chk("hold_if_pc", {34'h0, if_pc}, 64'h1);
      chk("hold_if_en", {63'h0, if_en}, 64'h0);
      chk("hold_bus_req", {63'h0, bus_req_}, 64'h1);
    end
    stall = 1'b0;
    repeat (3) @(negedge clk);

    // branch during ACCESS: in-flight word dropped
    fetch_grant(30'h2);
    br_taken = 1'b1;
    br_addr  = 30'h100;
    @(negedge clk);
    br_taken = 1'b0;
    chk("branch_if_en", {63'h0, if_en}, 64'h0);
    repeat (3) @(negedge clk);
    s = '{pc: 30'h101, insn: 32'hA5A5_0100, err: 1'b0};
    exp_slots.push_back(s);
    fetch_grant(30'h100);
    repeat (3) @(negedge clk);

    // flush beats branch in the same cycle
    flush    = 1'b1;
    new_pc   = 30'h200;
    br_taken = 1'b1;
    br_addr  = 30'h100;
    @(negedge clk);
    flush    = 1'b0;
    br_taken = 1'b0;
    chk("flush_if_insn", {32'h0, if_insn}, 64'h0);
    chk("flush_if_en", {63'h0, if_en}, 64'h0);
    s = '{pc: 30'h201, insn: 32'hA5A5_0200, err: 1'b0};
    exp_slots.push_back(s);
    fetch_grant(30'h200);
    repeat (3) @(negedge clk);

    // PC wrap at the top of the address space
    flush  = 1'b1;
    new_pc = 30'h3FFF_FFFF;
    @(negedge clk);
    flush = 1'b0;
    s = '{pc: 30'h0, insn: 32'hBFFF_FFFF, err: 1'b0};
    exp_slots.push_back(s);
    fetch_grant(30'h3FFF_FFFF);
    repeat (3) @(negedge clk);
    s = '{pc: 30'h1, insn: 32'h1234_5678, err: 1'b0};
    exp_slots.push_back(s);
    fetch_grant(30'h0);
    repeat (3) @(negedge clk);

    // slave never answers
    rdy_never = 1;
`ifdef IF_FETCH_TIMEOUT_EN
    s = '{pc: 30'h2, insn: 32'h0, err: 1'b1};
    exp_slots.push_back(s);
`endif
    fetch_grant(30'h1);
    repeat (4) @(negedge clk);
`ifdef IF_FETCH_TIMEOUT_EN
    chk("timeout_err", {63'h0, if_bus_err}, 64'h1);
    chk("timeout_if_en", {63'h0, if_en}, 64'h1);
    chk("timeout_bus_req", {63'h0, bus_req_}, 64'h1);
`else
    chk("wait_busy", {63'h0, busy}, 64'h1);
    chk("wait_bus_req", {63'h0, bus_req_}, 64'h0);
    chk("wait_if_err", {63'h0, if_bus_err}, 64'h0);
`endif
    repeat (4) @(negedge clk);

    // asynchronous reset mid-cycle
    #3 reset = 1'b0;
    #1;
    chk("async_bus_req", {63'h0, bus_req_}, 64'h1);
    chk("async_busy", {63'h0, busy}, 64'h0);
    chk("async_if_en", {63'h0, if_en}, 64'h0);
    rdy_never = 0;
    repeat (3) @(negedge clk);

    chk("addr_queue_drained", 64'(exp_addrs.size()), 64'h0);
    chk("slot_queue_drained", 64'(exp_slots.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
